// File: rtl/npc_unit_if.sv
// Purpose : bundles the ID-stage redirect request and the fetch-PC/RAS status of npc_unit.
// Latency : wires only; no storage.
// Backpress: stall travels on this bundle and freezes the consumer; there is no ready path back.
// Ports (slave = npc_unit view):
//   in : stall, exc_req, id_pc4, id_imm16, id_imm26, br_taken, jmp, link, jr, jr_ret, jr_target
//   out: pc, pc4, ras_top, ras_valid, jr_misalign, ras_miss_cnt
interface npc_unit_if #(
  parameter int AW    = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             exc_req;
  logic [AW-1:0]    id_pc4;
  logic [15:0]      id_imm16;
  logic [25:0]      id_imm26;
  logic             br_taken;
  logic             jmp;
  logic             link;
  logic             jr;
  logic             jr_ret;
  logic [AW-1:0]    jr_target;

  logic [AW-1:0]    pc;
  logic [AW-1:0]    pc4;
  logic [AW-1:0]    ras_top;
  logic             ras_valid;
  logic             jr_misalign;
  logic [CNT_W-1:0] ras_miss_cnt;

  // Pipeline/ID side: drives the redirect request, observes fetch state.
  modport master (
    output stall, exc_req, id_pc4, id_imm16, id_imm26, br_taken, jmp, link, jr, jr_ret, jr_target,
    input  pc, pc4, ras_top, ras_valid, jr_misalign, ras_miss_cnt
  );

  // npc_unit side.
  modport slave (
    input  stall, exc_req, id_pc4, id_imm16, id_imm26, br_taken, jmp, link, jr, jr_ret, jr_target,
    output pc, pc4, ras_top, ras_valid, jr_misalign, ras_miss_cnt
  );
endinterface

// File: rtl/npc_unit.sv
// Purpose : fetch PC register + next-PC select (exception/JR/J/branch/PC+4) with a circular return-address stack.
// Latency : a redirect presented in cycle N appears on pc in cycle N+1; pc4/ras_top/ras_valid are combinational from state.
// Backpress: stall holds pc and freezes RAS/misalign/mispredict state; exc_req overrides stall.
// Ports: clk, reset_n (async, active-low); npc (npc_unit_if.slave) carries all ID inputs and PC/RAS outputs.
module npc_unit #(
  parameter int          AW         = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          RAS_DEPTH  = 4,
  parameter int          CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  npc_unit_if.slave  npc
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int OW = $clog2(RAS_DEPTH + 1);
  localparam logic [AW-1:0] RESET_PC_W = AW'(RESET_PC);
  localparam logic [AW-1:0] EXC_VEC_W  = AW'(EXC_VECTOR);
  localparam logic [OW-1:0] OCC_FULL   = OW'(RAS_DEPTH);

  logic [AW-1:0]    pc_q;
  logic [AW-1:0]    pc_nxt;
  logic [AW-1:0]    pc4_w;
  logic [AW-1:0]    br_tgt;
  logic [AW-1:0]    j_tgt;
  logic [AW-1:0]    jr_tgt;
  logic [AW-29:0]   seg_hi;

  logic [AW-1:0]    ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic [PW-1:0]    top_idx;
  logic [OW-1:0]    ras_occ;
  logic             ras_valid_w;
  logic [AW-1:0]    ras_top_w;

  logic             misalign_q;
  logic [CNT_W-1:0] miss_q;

  logic             accept;
  logic             do_push;
  logic             do_pop;

  assign pc4_w  = pc_q + AW'(4);
  assign br_tgt = npc.id_pc4 + {{(AW-18){npc.id_imm16[15]}}, npc.id_imm16, 2'b00};
  assign jr_tgt = {npc.jr_target[AW-1:2], 2'b00};

  // Region bits come from the delay-slot PC (id_pc4 - 4). Subtracting 4 only
  // borrows into bit 28 when bits [27:2] of id_pc4 are all zero.
  assign seg_hi = npc.id_pc4[AW-1:28] - {{(AW-29){1'b0}}, (npc.id_pc4[27:2] == '0)};
  assign j_tgt  = {seg_hi, npc.id_imm26, 2'b00};

  assign accept  = ~npc.stall & ~npc.exc_req;
  // jr takes the PC when both jr and jmp are set, so the JAL push is dropped.
  assign do_push = accept & npc.jmp & npc.link & ~npc.jr;
  assign do_pop  = accept & npc.jr & npc.jr_ret;

  assign ras_valid_w = (ras_occ != '0);
  assign top_idx     = ras_ptr - PW'(1);
  assign ras_top_w   = ras_valid_w ? ras_mem[top_idx] : '0;

  always_comb begin
    pc_nxt = pc4_w;
    if (npc.exc_req)     pc_nxt = EXC_VEC_W;
    else if (npc.stall)  pc_nxt = pc_q;
    else if (npc.jr)     pc_nxt = jr_tgt;
    else if (npc.jmp)    pc_nxt = j_tgt;
    else if (npc.br_taken) pc_nxt = br_tgt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC_W;
      ras_ptr    <= '0;
      ras_occ    <= '0;
      misalign_q <= 1'b0;
      miss_q     <= '0;
    end else begin
      pc_q <= pc_nxt;

      if (accept && npc.jr) begin
        misalign_q <= (npc.jr_target[1:0] != 2'b00);
      end

      if (do_push) begin
        ras_ptr <= ras_ptr + PW'(1);
        // Once full, the pointer keeps wrapping and overwrites the oldest slot.
        if (ras_occ != OCC_FULL) ras_occ <= ras_occ + OW'(1);
      end else if (do_pop) begin
        if (ras_valid_w) begin
          ras_ptr <= top_idx;
          ras_occ <= ras_occ - OW'(1);
          if ((ras_top_w != jr_tgt) && (miss_q != '1)) miss_q <= miss_q + CNT_W'(1);
        end else if (miss_q != '1) begin
          // Return with nothing predicted is a mispredict too.
          miss_q <= miss_q + CNT_W'(1);
        end
      end
    end
  end

  // Contents are only meaningful below the occupancy count, so no reset here.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[ras_ptr] <= npc.id_pc4 + AW'(4);
  end

  assign npc.pc           = pc_q;
  assign npc.pc4          = pc4_w;
  assign npc.ras_top      = ras_top_w;
  assign npc.ras_valid    = ras_valid_w;
  assign npc.jr_misalign  = misalign_q;
  assign npc.ras_miss_cnt = miss_q;

endmodule

// File: tb/tb_npc_unit.sv
// Purpose : directed + randomized bench for npc_unit against a queue-based reference model.
// Latency : model state advances on each rising edge; outputs sampled 1ns later.
// Backpress: stall/exc_req are driven as part of the stimulus.
module tb_npc_unit;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  npc_unit_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

  npc_unit #(
    .AW(AW), .RESET_PC(32'h0000_3000), .EXC_VECTOR(32'h0000_4180),
    .RAS_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .npc(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: the RAS is simply the list of live return addresses, newest last.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int          m_miss;
  bit          m_mis;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0000_3000;
    m_ras.delete();
    m_miss = 0;
    m_mis  = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] tgt, top;
    if (bus.exc_req) begin
      m_pc = 32'h0000_4180;
    end else if (!bus.stall) begin
      if (bus.jr) begin
        tgt   = bus.jr_target & ~32'd3;
        m_pc  = tgt;
        m_mis = (bus.jr_target % 4) != 0;
        if (bus.jr_ret) begin
          if (m_ras.size() > 0) begin
            top = m_ras.pop_back();
            if (top != tgt && m_miss < 65535) m_miss++;
          end else if (m_miss < 65535) begin
            m_miss++;
          end
        end
      end else if (bus.jmp) begin
        m_pc = ((bus.id_pc4 - 32'd4) & 32'hF000_0000) | (32'(bus.id_imm26) * 4);
        if (bus.link) begin
          m_ras.push_back(bus.id_pc4 + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end else if (bus.br_taken) begin
        m_pc = bus.id_pc4 + 32'(int'($signed(bus.id_imm16)) * 4);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_top;
    exp_top = (m_ras.size() > 0) ? m_ras[$] : 32'd0;
    chk_val("pc",        bus.pc,           m_pc);
    chk_val("pc4",       bus.pc4,          m_pc + 32'd4);
    chk_val("ras_valid", bus.ras_valid,    m_ras.size() > 0);
    chk_val("ras_top",   bus.ras_top,      exp_top);
    chk_val("misalign",  bus.jr_misalign,  m_mis);
    chk_val("miss_cnt",  bus.ras_miss_cnt, m_miss);
  endtask

  task automatic idle();
    bus.stall = 0; bus.exc_req = 0; bus.id_pc4 = 0; bus.id_imm16 = 0; bus.id_imm26 = 0;
    bus.br_taken = 0; bus.jmp = 0; bus.link = 0; bus.jr = 0; bus.jr_ret = 0; bus.jr_target = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    idle();
  endtask

  task automatic do_jal(input logic [31:0] pc4v);
    bus.id_pc4 = pc4v; bus.id_imm26 = 26'h0000C40; bus.jmp = 1; bus.link = 1;
    step();
  endtask

  task automatic do_ret(input logic [31:0] tgt);
    bus.jr = 1; bus.jr_ret = 1; bus.jr_target = tgt;
    step();
  endtask

  initial begin
    logic [31:0] r;
    reset_n = 1'b0;
    idle();
    model_reset();
    #12;
    chk_val("rst_pc",    bus.pc,           32'h3000);
    chk_val("rst_valid", bus.ras_valid,    0);
    chk_val("rst_top",   bus.ras_top,      0);
    chk_val("rst_miss",  bus.ras_miss_cnt, 0);
    chk_val("rst_mis",   bus.jr_misalign,  0);
    reset_n = 1'b1;

    // Sequential fetch
    step(); chk_val("seq1", bus.pc, 32'h3004);
    step(); chk_val("seq2", bus.pc, 32'h3008);

    // Backward branch and absolute jump
    bus.id_pc4 = 32'h3010; bus.id_imm16 = 16'hFFFC; bus.br_taken = 1;
    step(); chk_val("br_back", bus.pc, 32'h3000);
    bus.id_pc4 = 32'h3010; bus.id_imm26 = 26'h0000C40; bus.jmp = 1;
    step(); chk_val("jump", bus.pc, 32'h3100);

    // Stall holds, exception overrides stall
    for (int i = 0; i < 2; i++) begin
      bus.stall = 1; bus.br_taken = 1; bus.id_pc4 = 32'h3010; bus.id_imm16 = 16'hFFFC;
      step(); chk_val("stall_hold", bus.pc, 32'h3100);
    end
    bus.stall = 1; bus.exc_req = 1;
    step(); chk_val("exc_stall", bus.pc, 32'h4180);
    chk_val("exc_ras", bus.ras_valid, 0);

    // Call/return pairing
    do_jal(32'h3020);
    chk_val("jal_top", bus.ras_top, 32'h3024);
    chk_val("jal_vld", bus.ras_valid, 1);
    do_ret(32'h3024);
    chk_val("ret_pc", bus.pc, 32'h3024);
    chk_val("ret_vld", bus.ras_valid, 0);
    chk_val("ret_miss", bus.ras_miss_cnt, 0);
    do_ret(32'h5000);
    chk_val("empty_pop_miss", bus.ras_miss_cnt, 1);

    // Overflow drops the oldest entry
    for (int i = 0; i < 5; i++) do_jal(32'h3000 + 32'(i) * 32'h100);
    chk_val("ovf_top", bus.ras_top, 32'h3404);
    for (int i = 0; i < 4; i++) begin
      r = 32'h3404 - 32'(i) * 32'h100;
      chk_val("pop_top", bus.ras_top, r);
      do_ret(r);
    end
    chk_val("drained", bus.ras_valid, 0);
    chk_val("drain_miss", bus.ras_miss_cnt, 1);
    do_ret(32'h3000);
    chk_val("fifth_pop_miss", bus.ras_miss_cnt, 2);

    // Misaligned JR target
    bus.jr = 1; bus.jr_target = 32'h3007;
    step();
    chk_val("jr_align_pc", bus.pc, 32'h3004);
    chk_val("jr_misalign", bus.jr_misalign, 1);

    // jr beats jmp, and the JAL push is suppressed
    do_jal(32'h3500);
    bus.jr = 1; bus.jmp = 1; bus.link = 1; bus.id_pc4 = 32'h3700; bus.jr_target = 32'h3600;
    step();
    chk_val("jr_jmp_pc", bus.pc, 32'h3600);
    chk_val("jr_jmp_top", bus.ras_top, 32'h3504);
    chk_val("jr_misalign_clr", bus.jr_misalign, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.stall    = ($urandom_range(0, 9) < 2);
      bus.exc_req  = ($urandom_range(0, 19) == 0);
      r            = $urandom;
      bus.id_pc4   = ($urandom_range(0, 9) == 0) ? (r & 32'hF000_0000) : (r & ~32'd3);
      bus.id_imm16 = 16'($urandom);
      bus.id_imm26 = 26'($urandom);
      bus.br_taken = ($urandom_range(0, 4) == 0);
      bus.jmp      = ($urandom_range(0, 5) == 0);
      bus.link     = ($urandom_range(0, 9) < 7);
      bus.jr       = ($urandom_range(0, 6) == 0);
      bus.jr_ret   = ($urandom_range(0, 9) < 7);
      if (m_ras.size() > 0 && $urandom_range(0, 2) != 0) bus.jr_target = m_ras[$];
      else bus.jr_target = $urandom & ~32'd3;
      if ($urandom_range(0, 3) == 0) bus.jr_target = bus.jr_target | 32'($urandom_range(0, 3));
      step();
    end

    // Asynchronous reset in the middle of activity
    do_jal(32'h3800);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_val("mid_rst_pc",    bus.pc,           32'h3000);
    chk_val("mid_rst_valid", bus.ras_valid,    0);
    chk_val("mid_rst_miss",  bus.ras_miss_cnt, 0);
    check_all();
    #1;
    reset_n = 1'b1;
    step(); chk_val("post_rst_pc", bus.pc, 32'h3004);
    do_ret(32'h3804);
    chk_val("post_rst_miss", bus.ras_miss_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
